if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch initiator for the CPU front end. It owns the program counter and drives the chip-enable/address pair into the instruction memory. It captures the returned instruction word in the same cycle, because the memory read is combinational. Each instruction and its PC are pushed into a small fetch buffer, which hands them to the decode stage over a valid/ready handshake. The unit also applies branch redirects from the execute/decode path.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FETCH_DEPTH`, 2: fetch buffer entries. Power of two, ≥2.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `branch_flag_i`, in, 1: redirect request, qualified this cycle.
- `branch_target_addr_i`, in, `InstAddrBus`: redirect target.
- `rom_ce_o`, out, 1: instruction memory chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o`, out, `InstAddrBus`: byte address to instruction memory.
- `rom_data_i`, in, `InstBus`: instruction word, valid in the same cycle `rom_ce_o` is high.
- `id_valid_o`, out, 1: head of buffer valid toward decode.
- `id_ready_i`, in, 1: decode accepts the head this cycle.
- `id_pc_o`, out, `InstAddrBus`: PC of head instruction.
- `id_inst_o`, out, `InstBus`: head instruction word.

## Operation
- **State machine:** `S_RESET` → `S_RUN`.
  - `rst` high forces `S_RESET`.
  - The first cycle after `rst` deasserts is spent in `S_RESET` with `rom_ce_o`=0.
  - The unit then moves to `S_RUN`. That first fetch is issued one cycle after reset release.
- **Handshakes:**
  - pop = `id_valid_o` && `id_ready_i`.
  - fetch = `S_RUN` && !`branch_flag_i` && (count < `FETCH_DEPTH` || pop).
- **Outputs:**
  - `rom_ce_o` = fetch, combinational.
  - `rom_addr_o` = pc at all times.
- **On fetch:**
  - Push {pc, `rom_data_i`} into the buffer.
  - pc ← pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- **Redirect:** `branch_flag_i` high in `S_RUN` or `S_RESET`:
  - Buffer emptied at the clock edge.
  - pc ← {`branch_target_addr_i`[31:2], 2'b00}; low two bits are always forced to zero.
  - No fetch that cycle.
  - Fetch from the target starts the next cycle.
- **Head output:**
  - `id_valid_o` = !empty && !`branch_flag_i`. The head is suppressed during a redirect cycle, so decode never accepts a wrong-path word.
  - `id_pc_o`/`id_inst_o` show the head entry when non-empty, `ZeroWord` when empty.
- **Simultaneous events:**
  - Pop and push in the same cycle: count unchanged, order preserved.
  - Pop with full buffer: the push is allowed.
  - Redirect with a pending pop: the pop is void, because `id_valid_o`=0.
- **Priority:** `rst` > `branch_flag_i` > push/pop.

## Timing
- **Reset values:**
  - pc = `RESET_PC`.
  - `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`.
  - Buffer empty, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0.
- **Fetch latency:** fetch at edge N makes the entry visible on `id_*` during cycle N+1 (one cycle).
- **Throughput:** one instruction/cycle when `id_ready_i` is held high.
- **Redirect penalty:**
  - Redirect in cycle R.
  - Target fetched in R+1.
  - Target visible at decode in R+2.
- **Backpressure:** with `id_ready_i` low, exactly `FETCH_DEPTH` fetches are issued, then `rom_ce_o` drops and pc holds.
- **Reset mid-operation:** the buffer is discarded, and the first fetch is again `RESET_PC`, one cycle after release.
- **Memory contract:** the instruction memory returns a word combinationally. A registered memory would require a new design; that is out of scope.

## Structure
- **Shared `defines.v`:** `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `ChipDisable`, `RstEnable`; add `FetchDepth`, `FetchDepthLog2`.
- **FSM state encodings:** local parameters.
- **Sub-module:** `fetch_fifo`, a synchronous FIFO of width `InstAddrBus`+`InstBus`.
  - Ports: `clk`, `rst`, flush, push, pop, full, empty, count.
  - Read-first head output and circular pointers with an extra wrap bit.
  - Flush resets the pointers.
- **Top level:** pc register, FSM, fetch/pop glue.

## Test plan
- **Reset release, `RESET_PC`=0, memory preloaded with words W0..W7, `id_ready_i`=1:**
  - `rom_ce_o`=0 for one cycle after release.
  - Then addresses 0,4,8,… on consecutive cycles.
  - `id_pc_o`/`id_inst_o` = 0/W0, 4/W1, … one per cycle.
- **Backpressure, `id_ready_i`=0 from the first valid cycle:**
  - Exactly 2 fetches (addr 0, 4), then `rom_ce_o`=0 and `rom_addr_o` holds at 8.
  - Raising `id_ready_i` yields W0, W1, then W2 with no gap or duplicate.
- **Redirect, `branch_flag_i`=1 with target 32'h40 while buffer holds 2 entries:**
  - `id_valid_o`=0 that cycle.
  - Next cycle `rom_addr_o`=0x40.
  - The cycle after, `id_pc_o`=0x40.
  - No pre-branch entry ever seen after the flush.
- **Misaligned target 32'h43:** fetch address 0x40, `id_pc_o`=0x40.
- **Wrap-around, redirect to 32'hFFFF_FFFC:** next fetch addresses FFFF_FFFC then 0000_0000.
- **Reset mid-stream (pc=0x20, buffer full):**
  - `rst` for 1 cycle clears `id_valid_o` the next cycle.
  - First post-reset fetch is 0x0, one cycle after release.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared bus widths, constants and fetch entry type
package if_fetch_unit_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstWidth     = 32;

    typedef logic [InstAddrWidth-1:0] inst_addr_t;
    typedef logic [InstWidth-1:0]     inst_t;

    localparam inst_t ZeroWord    = '0;
    localparam logic  ChipEnable  = 1'b1;
    localparam logic  ChipDisable = 1'b0;
    localparam logic  RstEnable   = 1'b1;

    localparam int FetchDepth     = 2;
    localparam int FetchDepthLog2 = 1;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - synchronous fetch buffer with flush and wrap-bit pointers
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Head is read combinationally, so a push into the slot being popped
    // (full + pop) never disturbs the word decode sees this cycle.
    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - program counter, fetch FSM and decode-side buffer glue
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = FetchDepth
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       branch_flag_i,
    input  inst_addr_t branch_target_addr_i,
    output logic       rom_ce_o,
    output inst_addr_t rom_addr_o,
    input  inst_t      rom_data_i,
    output logic       id_valid_o,
    input  logic       id_ready_i,
    output inst_addr_t id_pc_o,
    output inst_t      id_inst_o
);

    localparam int AW = $clog2(FETCH_DEPTH);

    localparam logic [0:0] S_RESET = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]   state;
    inst_addr_t   pc;
    logic         fetch;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  fifo_count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // A redirect hides the head so decode can never take a wrong-path word.
    assign id_valid_o = (fifo_count != '0) && !branch_flag_i;
    assign pop        = id_valid_o && id_ready_i;
    assign fetch      = (state == S_RUN) && !branch_flag_i && (!fifo_full || pop);

    assign rom_ce_o   = fetch ? ChipEnable : ChipDisable;
    assign rom_addr_o = pc;

    assign push_entry = '{pc: pc, inst: rom_data_i};
    assign id_pc_o    = fifo_empty ? ZeroWord : head_entry.pc;
    assign id_inst_o  = fifo_empty ? ZeroWord : head_entry.inst;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= S_RESET;
            pc    <= RESET_PC;
        end else begin
            state <= S_RUN;
            if (branch_flag_i) begin
                pc <= {branch_target_addr_i[31:2], 2'b00};
            end else if (fetch) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FETCH_DEPTH),
        .AW    (AW)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_flag_i),
        .push  (fetch),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
